// File: rtl/day_month.sv
// day_month: calendar day/month counter feeding the year counter; state updates one clk_1Hz edge after inputs, carry_out is combinational.
// FULL_LEAP_RULE_EN selects the full Gregorian leap rule; otherwise every year divisible by 4 is leap.
module day_month #(
  parameter logic [2:0] SELECT_DAY   = 3'b011,
  parameter logic [2:0] SELECT_MONTH = 3'b100,
  parameter logic [4:0] DAY_RST      = 5'd1,
  parameter logic [3:0] MONTH_RST    = 4'd1
) (
  input  logic        clk_1Hz,
  input  logic        rst,
  input  logic        en_1,
  input  logic        up,
  input  logic        down,
  input  logic [2:0]  select_item,
  input  logic        carry_in,
  input  logic [11:0] year_bin,
  output logic [4:0]  day_bin,
  output logic [3:0]  month_bin,
  output logic        carry_out
);

  logic       leap_y;
  logic       sel_day;
  logic       sel_month;
  logic       adjust_req;
  logic       count_tick;
  logic [4:0] cur_last;
  logic [4:0] new_last;
  logic [3:0] month_up;
  logic [3:0] month_dn;
  logic [4:0] day_nxt;
  logic [3:0] month_nxt;

  function automatic logic [4:0] last_day(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                    last_day = lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: last_day = 5'd30;
      default:                 last_day = 5'd31;
    endcase
  endfunction

`ifdef FULL_LEAP_RULE_EN
  logic century;
  logic quad_century;

  // year_bin is confined to 2001..3000, so the century exceptions are a short constant list
  always_comb begin
    century      = 1'b0;
    quad_century = 1'b0;
    case (year_bin)
      12'd2100, 12'd2200, 12'd2300, 12'd2500,
      12'd2600, 12'd2700, 12'd2900, 12'd3000: century      = 1'b1;
      12'd2400, 12'd2800:                     quad_century = 1'b1;
      default: ;
    endcase
  end

  assign leap_y = ((year_bin[1:0] == 2'b00) && !century) || quad_century;
`else
  assign leap_y = (year_bin[1:0] == 2'b00);
`endif

  assign sel_day    = (select_item == SELECT_DAY);
  assign sel_month  = (select_item == SELECT_MONTH);
  assign adjust_req = up || down;
  assign count_tick = en_1 && carry_in && !sel_day && !sel_month;
  assign cur_last   = last_day(month_bin, leap_y);
  assign month_up   = (month_bin >= 4'd12) ? 4'd1 : month_bin + 4'd1;
  assign month_dn   = (month_bin <= 4'd1) ? 4'd12 : month_bin - 4'd1;
  assign new_last   = last_day(month_nxt, leap_y);

  always_comb begin
    day_nxt   = day_bin;
    month_nxt = month_bin;
    if (sel_day && adjust_req) begin
      if (up)
        day_nxt = (day_bin >= cur_last) ? 5'd1 : day_bin + 5'd1;
      else
        day_nxt = (day_bin <= 5'd1) ? cur_last : day_bin - 5'd1;
    end else if (sel_month && adjust_req) begin
      month_nxt = up ? month_up : month_dn;
    end else if (count_tick) begin
      // a day beyond last_day (left over from a year change) rolls over like the last day
      if (day_bin < cur_last) begin
        day_nxt = day_bin + 5'd1;
      end else begin
        day_nxt   = 5'd1;
        month_nxt = month_up;
      end
    end else if (day_bin > cur_last) begin
      day_nxt = cur_last;
    end
  end

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      day_bin   <= DAY_RST;
      month_bin <= MONTH_RST;
    end else begin
      month_bin <= month_nxt;
      // month adjust clamps the day to the length of the month being entered
      if (sel_month && adjust_req && !sel_day && (day_nxt > new_last))
        day_bin <= new_last;
      else
        day_bin <= day_nxt;
    end
  end

  assign carry_out = !rst && count_tick && (month_bin == 4'd12) && (day_bin == 5'd31);

endmodule

// File: tb/tb_day_month.sv
module tb_day_month;

  logic        clk_1Hz;
  logic        rst;
  logic        en_1;
  logic        up;
  logic        down;
  logic [2:0]  select_item;
  logic        carry_in;
  logic [11:0] year_bin;
  logic [4:0]  day_bin;
  logic [3:0]  month_bin;
  logic        carry_out;

  int total = 0;
  int bad   = 0;
  int md    = 1;
  int mm    = 1;
  int month_len [1:12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  day_month dut (
    .clk_1Hz    (clk_1Hz),
    .rst        (rst),
    .en_1       (en_1),
    .up         (up),
    .down       (down),
    .select_item(select_item),
    .carry_in   (carry_in),
    .year_bin   (year_bin),
    .day_bin    (day_bin),
    .month_bin  (month_bin),
    .carry_out  (carry_out)
  );

  initial clk_1Hz = 1'b0;
  always #5 clk_1Hz = ~clk_1Hz;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  function automatic bit is_leap(int y);
`ifdef FULL_LEAP_RULE_EN
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
`else
    return (y % 4) == 0;
`endif
  endfunction

  function automatic int mlen(int m, int y);
    if (m == 2 && is_leap(y)) return 29;
    return month_len[m];
  endfunction

  function automatic bit model_carry();
    return en_1 && carry_in && select_item != 3'b011 && select_item != 3'b100 &&
           mm == 12 && md == 31;
  endfunction

  task automatic model_next(output int nd, output int nm);
    int y;
    int lim;
    y   = int'(year_bin);
    lim = mlen(mm, y);
    nd  = md;
    nm  = mm;
    if (select_item == 3'b011 && (up || down)) begin
      if (up) nd = (md >= lim) ? 1 : md + 1;
      else    nd = (md == 1) ? lim : md - 1;
    end else if (select_item == 3'b100 && (up || down)) begin
      nm = up ? (mm % 12) + 1 : ((mm == 1) ? 12 : mm - 1);
      if (md > mlen(nm, y)) nd = mlen(nm, y);
    end else if (select_item != 3'b011 && select_item != 3'b100 && en_1 && carry_in) begin
      if (md < lim) nd = md + 1;
      else begin
        nd = 1;
        nm = (mm % 12) + 1;
      end
    end else if (md > lim) begin
      nd = lim;
    end
  endtask

  task automatic step();
    int nd;
    int nm;
    model_next(nd, nm);
    @(posedge clk_1Hz);
    #1;
    md = nd;
    mm = nm;
  endtask

  task automatic idle_inputs();
    en_1 = 0; up = 0; down = 0; carry_in = 0; select_item = 3'b000;
  endtask

  task automatic set_date(int d, int m);
    idle_inputs();
    rst = 1;
    #2;
    rst = 0;
    md = 1;
    mm = 1;
    select_item = 3'b100; up = 1;
    for (int i = 1; i < m; i++) step();
    select_item = 3'b011;
    for (int i = 1; i < d; i++) step();
    idle_inputs();
  endtask

  task automatic test_reset();
    year_bin = 12'd2023;
    set_date(14, 6);
    en_1 = 1; carry_in = 1;
    step();
    total++;
    if (day_bin !== 5'd15 || month_bin !== 4'd6) begin
      bad++; $display("FAIL reset_pre: got %0d/%0d want 15/6", day_bin, month_bin);
    end
    rst = 1;
    #2;
    total++;
    if (day_bin !== 5'd1) begin bad++; $display("FAIL reset_day: got %0d want 1", day_bin); end
    total++;
    if (month_bin !== 4'd1) begin bad++; $display("FAIL reset_month: got %0d want 1", month_bin); end
    total++;
    if (carry_out !== 1'b0) begin bad++; $display("FAIL reset_carry: got %b want 0", carry_out); end
    rst = 0;
    md = 1; mm = 1;
    step();
    total++;
    if (day_bin !== 5'd2 || month_bin !== 4'd1) begin
      bad++; $display("FAIL reset_resume: got %0d/%0d want 2/1", day_bin, month_bin);
    end
    idle_inputs();
  endtask

  task automatic test_feb_rollover();
    year_bin = 12'd2023;
    set_date(28, 2);
    en_1 = 1; carry_in = 1;
    step();
    total++;
    if (day_bin !== 5'd1 || month_bin !== 4'd3) begin
      bad++; $display("FAIL feb_2023: got %0d/%0d want 1/3", day_bin, month_bin);
    end
    year_bin = 12'd2024;
    set_date(28, 2);
    en_1 = 1; carry_in = 1;
    step();
    total++;
    if (day_bin !== 5'd29 || month_bin !== 4'd2) begin
      bad++; $display("FAIL feb_2024_29: got %0d/%0d want 29/2", day_bin, month_bin);
    end
    step();
    total++;
    if (day_bin !== 5'd1 || month_bin !== 4'd3) begin
      bad++; $display("FAIL feb_2024_mar: got %0d/%0d want 1/3", day_bin, month_bin);
    end
    idle_inputs();
  endtask

  task automatic test_year_carry();
    year_bin = 12'd2023;
    set_date(31, 12);
    en_1 = 1; carry_in = 1;
    #1;
    total++;
    if (carry_out !== 1'b1) begin bad++; $display("FAIL carry_dec31: got %b want 1", carry_out); end
    step();
    total++;
    if (day_bin !== 5'd1 || month_bin !== 4'd1) begin
      bad++; $display("FAIL carry_wrap: got %0d/%0d want 1/1", day_bin, month_bin);
    end
    total++;
    if (carry_out !== 1'b0) begin bad++; $display("FAIL carry_after: got %b want 0", carry_out); end
    idle_inputs();
  endtask

  task automatic test_month_adjust();
    year_bin = 12'd2023;
    set_date(31, 1);
    select_item = 3'b100; up = 1;
    step();
    total++;
    if (day_bin !== 5'd28 || month_bin !== 4'd2) begin
      bad++; $display("FAIL madj_up_2023: got %0d/%0d want 28/2", day_bin, month_bin);
    end
    year_bin = 12'd2024;
    set_date(31, 1);
    select_item = 3'b100; up = 1;
    step();
    total++;
    if (day_bin !== 5'd29 || month_bin !== 4'd2) begin
      bad++; $display("FAIL madj_up_2024: got %0d/%0d want 29/2", day_bin, month_bin);
    end
    year_bin = 12'd2023;
    set_date(31, 1);
    select_item = 3'b100; down = 1; en_1 = 1; carry_in = 1;
    step();
    total++;
    if (day_bin !== 5'd31 || month_bin !== 4'd12) begin
      bad++; $display("FAIL madj_down: got %0d/%0d want 31/12", day_bin, month_bin);
    end
    total++;
    if (carry_out !== 1'b0) begin bad++; $display("FAIL madj_carry: got %b want 0", carry_out); end
    idle_inputs();
  endtask

  task automatic test_day_adjust();
    year_bin = 12'd2023;
    set_date(1, 4);
    select_item = 3'b011; down = 1; en_1 = 1; carry_in = 1;
    #1;
    total++;
    if (carry_out !== 1'b0) begin bad++; $display("FAIL dadj_carry: got %b want 0", carry_out); end
    step();
    total++;
    if (day_bin !== 5'd30 || month_bin !== 4'd4) begin
      bad++; $display("FAIL dadj_down: got %0d/%0d want 30/4", day_bin, month_bin);
    end
    up = 1;
    step();
    total++;
    if (day_bin !== 5'd1 || month_bin !== 4'd4) begin
      bad++; $display("FAIL dadj_both: got %0d/%0d want 1/4", day_bin, month_bin);
    end
    set_date(31, 12);
    select_item = 3'b011; en_1 = 1; carry_in = 1;
    #1;
    total++;
    if (carry_out !== 1'b0) begin bad++; $display("FAIL dadj_dec31_carry: got %b want 0", carry_out); end
    step();
    total++;
    if (day_bin !== 5'd31 || month_bin !== 4'd12) begin
      bad++; $display("FAIL dadj_hold: got %0d/%0d want 31/12", day_bin, month_bin);
    end
    idle_inputs();
  endtask

  task automatic test_century();
    int exp_d;
    int exp_m;
    year_bin = 12'd2100;
    set_date(28, 2);
    en_1 = 1; carry_in = 1;
    step();
`ifdef FULL_LEAP_RULE_EN
    exp_d = 1; exp_m = 3;
`else
    exp_d = 29; exp_m = 2;
`endif
    total++;
    if (day_bin !== 5'(exp_d) || month_bin !== 4'(exp_m)) begin
      bad++; $display("FAIL century_2100: got %0d/%0d want %0d/%0d", day_bin, month_bin, exp_d, exp_m);
    end
    year_bin = 12'd2400;
    set_date(28, 2);
    en_1 = 1; carry_in = 1;
    step();
    total++;
    if (day_bin !== 5'd29 || month_bin !== 4'd2) begin
      bad++; $display("FAIL century_2400: got %0d/%0d want 29/2", day_bin, month_bin);
    end
    year_bin = 12'd2024;
    set_date(29, 2);
    year_bin = 12'd2023;
    step();
    total++;
    if (day_bin !== 5'd28 || month_bin !== 4'd2) begin
      bad++; $display("FAIL year_clamp: got %0d/%0d want 28/2", day_bin, month_bin);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int yrs [5] = '{2023, 2024, 2100, 2400, 2800};
    year_bin = 12'd2023;
    set_date(1, 1);
    for (int i = 0; i < 900; i++) begin
      en_1     = ($urandom_range(0, 7) != 0);
      carry_in = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 2) == 0);
      down     = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0:       select_item = 3'b011;
        1:       select_item = 3'b100;
        2:       select_item = 3'b101;
        3:       select_item = 3'($urandom);
        default: select_item = 3'b000;
      endcase
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0) year_bin = 12'(yrs[$urandom_range(0, 4)]);
        else year_bin = 12'($urandom_range(2001, 3000));
      end
      #1;
      total++;
      if (carry_out !== model_carry()) begin
        bad++; $display("FAIL rand_carry[%0d]: got %b want %b", i, carry_out, model_carry());
      end
      step();
      total++;
      if (day_bin !== 5'(md) || month_bin !== 4'(mm)) begin
        bad++; $display("FAIL rand_state[%0d]: got %0d/%0d want %0d/%0d", i, day_bin, month_bin, md, mm);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    year_bin = 12'd2023;
    #12;
    rst = 0;
    @(posedge clk_1Hz);
    #1;
    md = 1; mm = 1;
    test_reset();
    test_feb_rollover();
    test_year_carry();
    test_month_adjust();
    test_day_adjust();
    test_century();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/day_month.md
Name: day_month

Overview:
- Calendar day/month counter; sits directly upstream of the year counter in the clock/date chain.
- Consumes the day-rollover carry from the hour counter and the current year value (used for leap-year rules).
- Drives carry_out into the year counter's carry_in on the 31 Dec → 1 Jan rollover.
- Supports manual up/down adjustment of day and month, selected by the shared select_item code.

Parameters:
- SELECT_DAY, 3'b011, select_item code that puts the day field in adjust mode.
- SELECT_MONTH, 3'b100, select_item code that puts the month field in adjust mode.
- DAY_RST, 5'd1, day value after reset.
- MONTH_RST, 4'd1, month value after reset.

Ports:
- clk_1Hz  input  1  system tick clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en_1  input  1  counting enable.
- up  input  1  adjust increment, sampled per clock.
- down  input  1  adjust decrement, sampled per clock.
- select_item  input  3  adjust field select, shared code space (year code is 3'b101).
- carry_in  input  1  day-rollover pulse from the hour counter.
- year_bin  input  12  current year, binary, 2001..3000.
- day_bin  output  5  day of month, 1..31.
- month_bin  output  4  month, 1..12.
- carry_out  output  1  year-increment request, combinational.

Behaviour:
- Reset (rst=1, asynchronous): day_bin=DAY_RST, month_bin=MONTH_RST; carry_out=0 while reset is held.
- last_day(m,y) = 31 for m in {1,3,5,7,8,10,12}; 30 for m in {4,6,9,11}; Feb = 29 if leap(y), else 28.
- leap(y) = (y%4==0 && y%100!=0) || y%400==0 when FULL_LEAP_RULE_EN is defined; see Optional Feature.
- Mode priority per clock edge, highest first: day adjust, month adjust, count.
- Day adjust (select_item==SELECT_DAY):
  - up: day = (day==last_day) ? 1 : day+1.
  - else down: day = (day==1) ? last_day : day-1.
  - up and down both high: up wins. Month unchanged. No carry.
- Month adjust (select_item==SELECT_MONTH):
  - up: month wraps 12→1; else down: month wraps 1→12.
  - Same cycle: if day > last_day(new month, year_bin), day is clamped to that last_day.
  - Example: 31 Jan + up → 28 Feb (non-leap) or 29 Feb (leap). No carry.
- Count (any other select_item, including the year code), when en_1 && carry_in:
  - day < last_day: day+1.
  - day == last_day and month < 12: day=1, month+1.
  - day == last_day and month == 12: day=1, month=1.
- carry_out = en_1 & carry_in & (month==12) & (day==31) & not adjusting day/month.
  - Combinational, same cycle as the 31 Dec state, so the year counter increments on the same edge that wraps day/month to 1 Jan.
- Year-change consistency, in any cycle where no day/month update occurs:
  - If day > last_day(month, year_bin) (e.g. 29 Feb after the year is adjusted to non-leap), day is clamped to last_day on the next edge.
  - Lower priority than any day/month update in the same cycle.
- day/month values are always legal after reset; an illegal state is never produced.
- Width rules: all compares unsigned; year arithmetic done on the 12-bit year_bin only. No modulo divider: %4 uses year_bin[1:0]; %100/%400 via compare or constant table over 2001..3000.
- Reset mid-adjust or mid-count: asynchronous return to reset values; no pending carry retained.

Optional Feature:
- Macro: FULL_LEAP_RULE_EN.
- Defined: full Gregorian rule; 2100, 2200, 2300, 2500… are non-leap; 2400 is leap.
- Undefined: leap(y) = (year_bin[1:0]==0) only. Smaller logic; wrong for century years.

Test Plan:
- rst pulse mid-count at day=15, month=6 → immediately day_bin=1, month_bin=1, carry_out=0; counts resume after release.
- year_bin=2023, day=28, month=2, en_1=1, carry_in=1, select_item=3'b000 → next edge day=1, month=3; with year_bin=2024 → 29 Feb, then 1 Mar.
- day=31, month=12, en_1=1, carry_in=1 → carry_out=1 that cycle; next edge day=1, month=1; carry_out=0 after.
- select_item=SELECT_MONTH, day=31, month=1, year_bin=2023, up=1 → month=2, day=28; down=1 from month=1 → month=12, day=31 kept.
- select_item=SELECT_DAY, day=1, month=4, down=1 → day=30; up and down both high at day=30 → day=1; carry_in=1 ignored, carry_out=0.
- year_bin=2100, day=28, month=2, count tick:
  - FULL_LEAP_RULE_EN defined → 1 Mar.
  - FULL_LEAP_RULE_EN undefined → 29 Feb.
  - With the macro defined, setting day=29, month=2 while year_bin changes 2024→2023 → day=28 next edge.
